// File: rtl/led_sequencer.sv
// LED pattern sequencer: a debounced button steps through five display modes,
// and a prescaled tick animates the pattern inside the current mode.
module led_sequencer #(
  parameter int TICK_DIV = 2000000,
  parameter int DEBOUNCE = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic g,
  output logic r1,
  output logic r2,
  output logic r3,
  output logic r4
);

  typedef enum logic [2:0] {
    BLINK  = 3'd0,
    CHASE  = 3'd1,
    BOUNCE = 3'd2,
    ALL_ON = 3'd3,
    OFF    = 3'd4
  } mode_t;

  localparam logic [23:0] PRESC_MAX = 24'(TICK_DIV - 1);
  localparam logic [19:0] DB_MAX    = 20'(DEBOUNCE - 1);

  logic [23:0] presc_reg;
  logic [1:0]  sync_reg;
  logic        level_reg;
  logic [19:0] db_cnt_reg;
  mode_t       mode_reg, mode_next;
  logic [2:0]  step_reg;
  logic [2:0]  step_last;
  logic [4:0]  led_reg, led_next;
  logic        tick;
  logic        btn_s;
  logic        press;

  assign tick  = (presc_reg == PRESC_MAX);
  assign btn_s = sync_reg[1];
  // A press is the cycle in which a rising level is accepted.
  assign press = btn_s && !level_reg && (db_cnt_reg == DB_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg   <= 2'b00;
      level_reg  <= 1'b0;
      db_cnt_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], btn};
      if (btn_s == level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_MAX) begin
        level_reg  <= btn_s;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (press || tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg <= BLINK;
    end else begin
      mode_reg <= mode_next;
    end
  end

  always_comb begin
    mode_next = mode_reg;
    if (press) begin
      case (mode_reg)
        BLINK:   mode_next = CHASE;
        CHASE:   mode_next = BOUNCE;
        BOUNCE:  mode_next = ALL_ON;
        ALL_ON:  mode_next = OFF;
        default: mode_next = BLINK;
      endcase
    end
  end

  always_comb begin
    step_last = 3'd0;
    case (mode_reg)
      BLINK:   step_last = 3'd1;
      CHASE:   step_last = 3'd3;
      BOUNCE:  step_last = 3'd5;
      default: step_last = 3'd0;
    endcase
  end

  // Press takes priority over tick so a new mode always starts at step 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_reg <= 3'd0;
    end else if (press) begin
      step_reg <= 3'd0;
    end else if (tick) begin
      step_reg <= (step_reg >= step_last) ? 3'd0 : step_reg + 3'd1;
    end
  end

  // Bit order {g, r1, r2, r3, r4}.
  always_comb begin
    led_next = 5'b00000;
    case (mode_reg)
      BLINK: led_next = {step_reg[0], 4'b0000};
      CHASE: begin
        case (step_reg[1:0])
          2'd0:    led_next = 5'b01000;
          2'd1:    led_next = 5'b00100;
          2'd2:    led_next = 5'b00010;
          default: led_next = 5'b00001;
        endcase
      end
      BOUNCE: begin
        case (step_reg)
          3'd0:    led_next = 5'b01000;
          3'd1:    led_next = 5'b00100;
          3'd2:    led_next = 5'b00010;
          3'd3:    led_next = 5'b10001;
          3'd4:    led_next = 5'b00010;
          default: led_next = 5'b00100;
        endcase
      end
      ALL_ON:  led_next = 5'b11111;
      default: led_next = 5'b00000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg <= 5'b00000;
    end else begin
      led_reg <= led_next;
    end
  end

  assign {g, r1, r2, r3, r4} = led_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_DIV=4, DEBOUNCE=3.
// LED vectors are compared as {g, r1, r2, r3, r4}.
module tb_led_sequencer;

  logic clk;
  logic rst_n;
  logic btn;
  logic g, r1, r2, r3, r4;
  logic [4:0] leds;
  int pass_cnt;
  int total_cnt;

  led_sequencer #(.TICK_DIV(4), .DEBOUNCE(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .g     (g),
    .r1    (r1),
    .r2    (r2),
    .r3    (r3),
    .r4    (r4)
  );

  assign leds = {g, r1, r2, r3, r4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst_n released at a falling edge; the next rising edge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (leds !== 5'b00000)
      $display("FAIL reset_leds: got %b expected %b", leds, 5'b00000);
    else pass_cnt++;
  endtask

  task automatic test_blink();
    int exp_g [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    logic [4:0] exp;
    btn = 1'b0;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      tick_clk();
      exp = (exp_g[k-1] != 0) ? 5'b10000 : 5'b00000;
      total_cnt++;
      if (leds !== exp)
        $display("FAIL blink cycle %0d: got %b expected %b", k, leds, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_press_chase();
    logic [4:0] exp;
    btn = 1'b0;
    do_reset();
    btn = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick_clk();
      if (k <= 4) exp = 5'b00000;
      else if (k == 5) exp = 5'b10000;
      else begin
        case (((k - 6) / 4) % 4)
          0:       exp = 5'b01000;
          1:       exp = 5'b00100;
          2:       exp = 5'b00010;
          default: exp = 5'b00001;
        endcase
      end
      total_cnt++;
      if (leds !== exp)
        $display("FAIL chase cycle %0d: got %b expected %b", k, leds, exp);
      else pass_cnt++;
    end
    btn = 1'b0;
  endtask

  task automatic test_glitch();
    logic [4:0] exp;
    btn = 1'b0;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) btn = 1'b1;
      if (k == 3) btn = 1'b0;
      tick_clk();
      exp = ((((k - 1) / 4) % 2) != 0) ? 5'b10000 : 5'b00000;
      total_cnt++;
      if (leds !== exp)
        $display("FAIL glitch cycle %0d: got %b expected %b", k, leds, exp);
      else pass_cnt++;
    end
  endtask

  // Second press is accepted on edge 17, which is also a tick edge in CHASE.
  task automatic test_press_on_tick();
    logic [4:0] exp;
    btn = 1'b0;
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      if (k == 1)  btn = 1'b1;
      if (k == 7)  btn = 1'b0;
      if (k == 13) btn = 1'b1;
      tick_clk();
      if (k >= 17) begin
        if (k == 17) exp = 5'b00010;
        else if (k <= 21) exp = 5'b01000;
        else exp = 5'b00100;
        total_cnt++;
        if (leds !== exp)
          $display("FAIL press_on_tick cycle %0d: got %b expected %b", k, leds, exp);
        else pass_cnt++;
      end
    end
    btn = 1'b0;
  endtask

  task automatic test_mode_cycle();
    logic [4:0] exp10 [5] = '{5'b00100, 5'b00100, 5'b11111, 5'b00000, 5'b10000};
    logic [4:0] exp22 [5] = '{5'b01000, 5'b00010, 5'b11111, 5'b00000, 5'b00000};
    btn = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      for (int k = 1; k <= 24; k++) begin
        btn = (k <= 10);
        tick_clk();
        if (k == 10) begin
          total_cnt++;
          if (leds !== exp10[i])
            $display("FAIL mode_cycle press %0d step1: got %b expected %b", i + 1, leds, exp10[i]);
          else pass_cnt++;
        end
        if (k == 22) begin
          total_cnt++;
          if (leds !== exp22[i])
            $display("FAIL mode_cycle press %0d step4: got %b expected %b", i + 1, leds, exp22[i]);
          else pass_cnt++;
        end
      end
    end
    btn = 1'b0;
  endtask

  task automatic test_async_reset();
    btn = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 1; k <= 24; k++) begin
        btn = (k <= 10);
        tick_clk();
      end
    end
    btn = 1'b0;
    repeat (2) tick_clk();
    total_cnt++;
    if (leds !== 5'b11111)
      $display("FAIL async_reset all_on: got %b expected %b", leds, 5'b11111);
    else pass_cnt++;
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (leds !== 5'b00000)
      $display("FAIL async_reset clear: got %b expected %b", leds, 5'b00000);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick_clk();
      if (k == 1 || k == 5) begin
        total_cnt++;
        if (leds !== ((k == 5) ? 5'b10000 : 5'b00000))
          $display("FAIL async_reset blink cycle %0d: got %b expected %b", k, leds,
                   (k == 5) ? 5'b10000 : 5'b00000);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_hold_through_reset();
    logic [4:0] exp;
    btn = 1'b1;
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      tick_clk();
      if (k == 5 || k == 6 || k == 10 || k == 14) begin
        case (k)
          5:       exp = 5'b10000;
          6:       exp = 5'b01000;
          10:      exp = 5'b00100;
          default: exp = 5'b00010;
        endcase
        total_cnt++;
        if (leds !== exp)
          $display("FAIL hold_through_reset cycle %0d: got %b expected %b", k, leds, exp);
        else pass_cnt++;
      end
    end
    btn = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    btn       = 1'b0;
    test_reset();
    test_blink();
    test_press_chase();
    test_glitch();
    test_press_on_tick();
    test_mode_cycle();
    test_async_reset();
    test_hold_through_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
